multicycle_exec_core: RTL and testbench
=======================================

MULTICYCLE_EXEC_CORE -- requirements
Module: multicycle_exec_core

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath and register width; legal values 32 or 64.
REQ-002 SHALL have parameter NUM_REGS, default 32, meaning architectural register count; legal values 16 or 32.
REQ-003 SHALL have port clk  input  1  meaning single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset_n  input  1  meaning asynchronous, active-low reset.
REQ-005 SHALL have port instr_valid  input  1  meaning an instruction is offered.
REQ-006 SHALL have port instr_ready  output  1  meaning the core can accept an instruction this cycle.
REQ-007 SHALL have port instruction  input  32  meaning the instruction word, sampled on accept.
REQ-008 SHALL have port wb_valid  output  1  meaning a one-cycle pulse marking instruction completion.
REQ-009 SHALL have port wb_rd  output  5  meaning the destination index of the completing instruction.
REQ-010 SHALL have port wb_data  output  XLEN  meaning the result of the completing instruction.
REQ-011 SHALL have port illegal  output  1  meaning a one-cycle pulse, coincident with wb_valid, for an unsupported instruction.
REQ-012 SHALL have port retire_count  output  32  meaning the number of legal instructions retired.
REQ-013 SHALL have port dbg_addr  input  5  meaning the register index for the debug read.
REQ-014 SHALL have port dbg_data  output  XLEN  meaning the combinational read of register dbg_addr; reads 0 for index 0 and for indices >= NUM_REGS.

Function
REQ-015 SHALL implement FSM states IDLE, DECODE, EXECUTE, WRITEBACK; transitions: IDLE->DECODE on instr_valid&instr_ready, DECODE->EXECUTE, EXECUTE->WRITEBACK, WRITEBACK->IDLE, each after exactly one cycle.
REQ-016 SHALL drive instr_ready=1 only in IDLE; the instruction is latched internally on accept and the instruction port is ignored in all other states.
REQ-017 SHALL use fixed timing: accept at edge T; wb_valid high during the cycle after edge T+3; result visible on dbg_data after edge T+4; maximum throughput is one instruction per 4 cycles.
REQ-018 SHALL, in DECODE, register rs1=instr[19:15] and rs2=instr[24:20] operand values, the sign-extended immediate, and the legality flag.
REQ-019 SHALL support OP (0110011) with funct3/funct7 selecting ADD, SUB (funct7=0100000), SLL, SLT, SLTU, XOR, SRL, SRA (funct7=0100000), OR, AND.
REQ-020 SHALL support OP-IMM (0010011): ADDI, SLTI, SLTIU, XORI, ORI, ANDI with imm[11:0] sign-extended to XLEN; SLLI, SRLI, SRAI with shamt = low log2(XLEN) bits of instr[25:20].
REQ-021 SHALL support LUI (0110111) with result = instr[31:12]<<12, sign-extended from bit 31 to XLEN.
REQ-022 SHALL wrap all arithmetic modulo 2^XLEN; SLT/SLTI compare signed, SLTU/SLTIU compare unsigned with the sign-extended immediate; the shift amount uses only its low log2(XLEN) bits.
REQ-023 SHALL treat as illegal: any other opcode; OP with funct7 not in {0000000, 0100000}, or 0100000 on a funct3 other than ADD/SRL; SLLI/SRLI/SRAI with invalid upper immediate bits; any rd/rs1/rs2 index >= NUM_REGS.
REQ-024 SHALL hold EXECUTE result in a register; the ALU is not recomputed in WRITEBACK.
REQ-025 SHALL, in WRITEBACK for a legal instruction: write wb_data to rd if rd!=0, pulse wb_valid, and increment retire_count (wrapping 0xFFFFFFFF->0).
REQ-026 SHALL, in WRITEBACK for an illegal instruction: pulse wb_valid and illegal, drive wb_data=0, perform no register write, and not increment retire_count.
REQ-027 SHALL hardwire register 0 to zero; writes with rd=0 are discarded but still retire.
REQ-028 SHALL drive wb_rd and wb_data with the last completed values when wb_valid=0.

Reset
REQ-029 SHALL, on reset_n low, immediately enter IDLE and clear all registers, operand/result latches, wb_valid, illegal, wb_rd, wb_data and retire_count to 0; instr_ready=1 after release.
REQ-030 SHALL abandon an in-flight instruction on reset assertion mid-operation: no write, no wb_valid, and no count.

Verification
REQ-031 SHALL test: ADDI x1,x0,-1 -> wb_valid 4th cycle after accept, wb_data=0xFFFFFFFF, dbg x1=0xFFFFFFFF, retire_count=1.
REQ-032 SHALL test: x1=5, x2=7; SUB x3,x1,x2 -> 0xFFFFFFFE; SLTU x4,x1,x2 -> 1; SRA x5,x3,1 -> 0xFFFFFFFF.
REQ-033 SHALL test: LUI x6,0x80000 with XLEN=64 -> 0xFFFFFFFF80000000; with XLEN=32 -> 0x80000000.
REQ-034 SHALL test: opcode 0000011 with NUM_REGS=16 and rd=17 -> illegal=1, wb_data=0, no write, retire_count unchanged.
REQ-035 SHALL test: instr_valid held high continuously -> instr_ready high 1 cycle in 4; ADDI x0,x0,5 -> x0 reads 0 and retire_count increments.
REQ-036 SHALL test: reset_n pulsed low during EXECUTE -> no wb_valid, rd unchanged at 0, state IDLE, retire_count=0.

Source files
------------

// File: rtl/multicycle_exec_core.sv
// Four-state integer core: latch one instruction, decode, execute, write back, then accept the next.
// Latency: accepted at edge T, wb_valid during the cycle after edge T+3; one instruction per 4 cycles.
// Backpressure: instr_ready is high only in IDLE; the instruction port is ignored in every other state.

module multicycle_exec_core #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instruction,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            illegal,
  output logic [31:0]     retire_count,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  localparam int         SHW     = $clog2(XLEN);
  localparam logic [6:0] OPC_OP  = 7'b0110011;
  localparam logic [6:0] OPC_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI = 7'b0110111;
  // Upper immediate bits above the shift amount that mark SRAI (instr[30] set).
  localparam logic [11:0] SRA_HI = 12'h400 >> SHW;

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXECUTE, S_WRITEBACK} state_t;

  state_t                             state_q, state_d;
  logic [31:0]                        instr_q, instr_d;
  logic [XLEN-1:0]                    op_a_q, op_a_d;
  logic [XLEN-1:0]                    op_b_q, op_b_d;
  logic [XLEN-1:0]                    imm_q, imm_d;
  logic [XLEN-1:0]                    result_q, result_d;
  logic                               legal_q, legal_d;
  logic                               wb_valid_q, wb_valid_d;
  logic                               illegal_q, illegal_d;
  logic [4:0]                         wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]                    wb_data_q, wb_data_d;
  logic [31:0]                        retire_q, retire_d;
  logic [NUM_REGS-1:0][XLEN-1:0]      regs_q, regs_d;

  // Instruction fields, always taken from the latched word.
  logic [6:0]  opc;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [11:0] imm12;
  logic [11:0] imm_hi;

  assign opc    = instr_q[6:0];
  assign rd     = instr_q[11:7];
  assign f3     = instr_q[14:12];
  assign rs1    = instr_q[19:15];
  assign rs2    = instr_q[24:20];
  assign f7     = instr_q[31:25];
  assign imm12  = instr_q[31:20];
  assign imm_hi = imm12 >> SHW;

  function automatic logic idx_ok(input logic [4:0] idx);
    return {27'd0, idx} < 32'(NUM_REGS);
  endfunction

  // Index 0 holds a constant zero; indices past the file read as zero.
  function automatic logic [XLEN-1:0] rf_read(input logic [NUM_REGS-1:0][XLEN-1:0] rf,
                                               input logic [4:0] idx);
    logic [XLEN-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx == 5'(i)) v = rf[i];
    end
    return v;
  endfunction

  // Decode: legality and sign-extended immediate for the latched instruction.
  logic            legal_dec;
  logic            sh_ok;
  logic [XLEN-1:0] imm_dec;

  always_comb begin
    legal_dec = 1'b0;
    sh_ok     = 1'b1;
    imm_dec   = {{(XLEN-12){imm12[11]}}, imm12};
    case (opc)
      OPC_OP: begin
        legal_dec = (f7 == 7'b0000000 ||
                     (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))) &&
                    idx_ok(rd) && idx_ok(rs1) && idx_ok(rs2);
      end
      OPC_IMM: begin
        if (f3 == 3'b001) begin
          sh_ok = (imm_hi == 12'd0);
        end else if (f3 == 3'b101) begin
          sh_ok = (imm_hi == 12'd0) || (imm_hi == SRA_HI);
        end
        legal_dec = sh_ok && idx_ok(rd) && idx_ok(rs1);
      end
      OPC_LUI: begin
        legal_dec = idx_ok(rd);
        imm_dec   = {{(XLEN-31){instr_q[31]}}, instr_q[30:12], 12'h000};
      end
      default: legal_dec = 1'b0;
    endcase
  end

  // ALU on the registered operands; only consumed in EXECUTE.
  logic [XLEN-1:0]        alu_b;
  logic [XLEN-1:0]        alu_res;
  logic [SHW-1:0]         shamt;
  logic signed [XLEN-1:0] sra_res;
  logic                   lt_s;

  always_comb begin
    alu_b   = (opc == OPC_OP) ? op_b_q : imm_q;
    shamt   = alu_b[SHW-1:0];
    sra_res = $signed(op_a_q) >>> shamt;
    lt_s    = $signed(op_a_q) < $signed(alu_b);
    alu_res = '0;
    if (opc == OPC_LUI) begin
      alu_res = imm_q;
    end else begin
      case (f3)
        3'b000:  alu_res = (opc == OPC_OP && instr_q[30]) ? op_a_q - alu_b : op_a_q + alu_b;
        3'b001:  alu_res = op_a_q << shamt;
        3'b010:  alu_res = {{(XLEN-1){1'b0}}, lt_s};
        3'b011:  alu_res = {{(XLEN-1){1'b0}}, (op_a_q < alu_b)};
        3'b100:  alu_res = op_a_q ^ alu_b;
        3'b101:  alu_res = instr_q[30] ? sra_res : op_a_q >> shamt;
        3'b110:  alu_res = op_a_q | alu_b;
        default: alu_res = op_a_q & alu_b;
      endcase
    end
  end

  // FSM next state plus every latch update for the current phase.
  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    imm_d       = imm_q;
    legal_d     = legal_q;
    result_d    = result_q;
    wb_valid_d  = 1'b0;
    illegal_d   = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    retire_d    = retire_q;
    regs_d      = regs_q;
    instr_ready = (state_q == S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          instr_d = instruction;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        op_a_d  = rf_read(regs_q, rs1);
        op_b_d  = rf_read(regs_q, rs2);
        imm_d   = imm_dec;
        legal_d = legal_dec;
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        result_d = alu_res;
        state_d  = S_WRITEBACK;
      end
      default: begin
        wb_valid_d = 1'b1;
        illegal_d  = ~legal_q;
        wb_rd_d    = rd;
        wb_data_d  = legal_q ? result_q : '0;
        if (legal_q) begin
          retire_d = retire_q + 32'd1;
          for (int i = 1; i < NUM_REGS; i++) begin
            if (rd == 5'(i)) regs_d[i] = result_q;
          end
        end
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any in-flight instruction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      instr_q    <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      imm_q      <= '0;
      legal_q    <= 1'b0;
      result_q   <= '0;
      wb_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      retire_q   <= '0;
      regs_q     <= '0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      imm_q      <= imm_d;
      legal_q    <= legal_d;
      result_q   <= result_d;
      wb_valid_q <= wb_valid_d;
      illegal_q  <= illegal_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      retire_q   <= retire_d;
      regs_q     <= regs_d;
    end
  end

  assign wb_valid     = wb_valid_q;
  assign illegal      = illegal_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign retire_count = retire_q;
  assign dbg_data     = rf_read(regs_q, dbg_addr);

endmodule

// File: tb/tb_multicycle_exec_core.sv
// Randomized bench for multicycle_exec_core with an instruction-level reference model.
// Expected completions are queued at issue time; a monitor pops them on every wb_valid.
// Directed sequences cover reset, timing, x0, illegal encodings, burst issue and mid-op reset.

module tb_multicycle_exec_core;
  localparam int XLEN     = 64;
  localparam int NUM_REGS = 16;
  typedef logic [XLEN-1:0] word_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [31:0] instruction = '0;
  logic [4:0]  dbg_addr = '0;
  logic        instr_ready;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  word_t       wb_data;
  logic        illegal;
  logic [31:0] retire_count;
  word_t       dbg_data;

  multicycle_exec_core #(.XLEN(XLEN), .NUM_REGS(NUM_REGS)) dut (
    .clk(clk), .reset_n(reset_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instruction(instruction), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .illegal(illegal), .retire_count(retire_count), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [4:0]  rd;
    word_t       data;
    logic        ill;
    logic [31:0] rc;
    int          acc;
  } exp_t;

  exp_t        exp_q[$];
  word_t       mrf[32];
  logic [31:0] mrc;

  task automatic chk(input string name, input word_t act, input word_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: RISC-V integer semantics on a value-level register array.
  function automatic word_t alu(input logic [2:0] f3, input logic alt, input word_t a,
                                input word_t b, input int sh);
    word_t r;
    case (f3)
      3'd0: r = alt ? a - b : a + b;
      3'd1: r = a << sh;
      3'd2: r = ($signed(a) < $signed(b)) ? word_t'(1) : word_t'(0);
      3'd3: r = (a < b) ? word_t'(1) : word_t'(0);
      3'd4: r = a ^ b;
      3'd5: begin
        r = a >> sh;
        if (alt && a[XLEN-1]) r = r | ~(~word_t'(0) >> sh);
      end
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  function automatic void model(input logic [31:0] ins, output exp_t e);
    logic [6:0] opc;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    logic [6:0] f7;
    word_t      a, b, r;
    logic       ok;
    int         sh, hi;
    opc = ins[6:0]; rd = ins[11:7]; f3 = ins[14:12];
    rs1 = ins[19:15]; rs2 = ins[24:20]; f7 = ins[31:25];
    a  = mrf[rs1];
    r  = '0;
    ok = (int'(rd) < NUM_REGS);
    case (opc)
      7'b0110011: begin
        b  = mrf[rs2];
        ok = ok && int'(rs1) < NUM_REGS && int'(rs2) < NUM_REGS &&
             (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
        sh = int'(b % XLEN);
        r  = alu(f3, f7 == 7'h20, a, b, sh);
      end
      7'b0010011: begin
        b = word_t'(ins[31:20]);
        if (ins[31]) b = b - word_t'(4096);
        hi = int'(ins[31:20]) / XLEN;
        sh = int'(ins[31:20]) % XLEN;
        ok = ok && int'(rs1) < NUM_REGS;
        if (f3 == 3'd1) ok = ok && hi == 0;
        if (f3 == 3'd5) ok = ok && (hi == 0 || hi == 1024 / XLEN);
        r = alu(f3, f3 == 3'd5 && hi != 0, a, b, sh);
      end
      7'b0110111: begin
        r = word_t'({ins[31:12], 12'h000});
        if (ins[31]) r = r - (word_t'(1) << 32);
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      r = '0;
    end else begin
      if (rd != 5'd0) mrf[rd] = r;
      mrc = mrc + 32'd1;
    end
    e.rd = rd; e.data = r; e.ill = ~ok; e.rc = mrc; e.acc = 0;
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [4:0] pick_reg();
    if ($urandom_range(0, 9) == 0) return 5'($urandom_range(16, 31));
    return 5'($urandom_range(0, 15));
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [11:0] imm;
    int          k;
    k  = $urandom_range(0, 9);
    f3 = 3'($urandom);
    case (k)
      0, 1, 2: begin
        f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        if ($urandom_range(0, 7) == 0) f7 = 7'($urandom);
        return enc_r(f7, pick_reg(), pick_reg(), f3, pick_reg());
      end
      3, 4, 5: begin
        imm = 12'($urandom);
        if (f3 == 3'd1) imm = 12'($urandom_range(0, XLEN - 1));
        if (f3 == 3'd5) imm = 12'($urandom_range(0, XLEN - 1)) +
                              (($urandom_range(0, 1) == 1) ? 12'h400 : 12'h000);
        if ($urandom_range(0, 7) == 0) imm = 12'($urandom);
        return enc_i(imm, pick_reg(), f3, pick_reg());
      end
      6:       return {20'($urandom), pick_reg(), 7'b0110111};
      7:       return $urandom;
      default: return enc_i(12'($urandom), 5'd0, 3'd0, 5'($urandom_range(1, 15)));
    endcase
  endfunction

  // Monitor: every completion is checked against the queue head; between
  // completions the write-back outputs must hold their last values.
  logic [4:0] last_rd = '0;
  word_t      last_data = '0;

  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      last_rd   = '0;
      last_data = '0;
    end else if (wb_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_wb: got wb_valid rd=%0d data=%h, expected no completion",
                 wb_rd, wb_data);
      end else begin
        e = exp_q.pop_front();
        chk("wb_rd", word_t'(wb_rd), word_t'(e.rd));
        chk("wb_data", wb_data, e.data);
        chk("illegal", word_t'(illegal), word_t'(e.ill));
        chk("retire_count", word_t'(retire_count), word_t'(e.rc));
        chk("latency", word_t'(cyc - e.acc), word_t'(3));
      end
      last_rd   = wb_rd;
      last_data = wb_data;
    end else begin
      chk("hold_rd", word_t'(wb_rd), word_t'(last_rd));
      chk("hold_data", wb_data, last_data);
      chk("illegal_idle", word_t'(illegal), word_t'(0));
    end
  end

  // Called at a negedge; offers ins once the core is ready and queues its expectation.
  task automatic issue(input logic [31:0] ins, input logic hold, output int waits);
    exp_t e;
    waits = 0;
    while (!instr_ready && waits < 20) begin
      instr_valid = hold;
      instruction = $urandom;
      @(negedge clk);
      waits++;
    end
    if (!instr_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL ready_timeout: instr_ready got 0, expected 1");
      instr_valid = 1'b0;
      return;
    end
    instr_valid = 1'b1;
    instruction = ins;
    model(ins, e);
    e.acc = cyc + 1;
    exp_q.push_back(e);
    @(negedge clk);
    instr_valid = hold;
    instruction = $urandom;
  endtask

  task automatic drain();
    int t;
    t = 0;
    instr_valid = 1'b0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d completions outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic dbg_chk(input string name, input logic [4:0] idx, input word_t exp);
    dbg_addr = idx;
    #1;
    chk(name, dbg_data, exp);
  endtask

  task automatic dbg_sweep();
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      chk($sformatf("dbg_x%0d", i), dbg_data, (i < NUM_REGS) ? mrf[i] : word_t'(0));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected completion within time limit");
    $fatal(1);
  end

  initial begin
    int w;
    for (int i = 0; i < 32; i++) mrf[i] = '0;
    mrc = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", word_t'(instr_ready), word_t'(1));
    chk("rst_wb_valid", word_t'(wb_valid), word_t'(0));
    chk("rst_illegal", word_t'(illegal), word_t'(0));
    chk("rst_wb_rd", word_t'(wb_rd), word_t'(0));
    chk("rst_wb_data", wb_data, word_t'(0));
    chk("rst_retire", word_t'(retire_count), word_t'(0));
    dbg_sweep();
    @(negedge clk);

    // ADDI x1,x0,-1.
    issue(enc_i(12'hFFF, 5'd0, 3'd0, 5'd1), 1'b0, w);
    drain();
    dbg_chk("addi_x1", 5'd1, ~word_t'(0));
    chk("addi_retire", word_t'(retire_count), word_t'(1));
    @(negedge clk);

    // x1=5, x2=7; SUB x3; SLTU x4; SRAI x5,x3,1.
    issue(enc_i(12'd5, 5'd0, 3'd0, 5'd1), 1'b0, w);
    issue(enc_i(12'd7, 5'd0, 3'd0, 5'd2), 1'b0, w);
    issue(enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd3), 1'b0, w);
    issue(enc_r(7'h00, 5'd2, 5'd1, 3'd3, 5'd4), 1'b0, w);
    issue(enc_i(12'h401, 5'd3, 3'd5, 5'd5), 1'b0, w);
    drain();
    dbg_chk("sub_x3", 5'd3, ~word_t'(1));
    dbg_chk("sltu_x4", 5'd4, word_t'(1));
    dbg_chk("sra_x5", 5'd5, ~word_t'(0));
    @(negedge clk);

    // LUI x6,0x80000 sign-extends to 64 bits.
    issue({20'h80000, 5'd6, 7'b0110111}, 1'b0, w);
    drain();
    dbg_chk("lui_x6", 5'd6, word_t'(64'hFFFF_FFFF_8000_0000));
    @(negedge clk);

    // Unsupported opcode with rd=17, and ADDI to x17 (outside a 16-entry file).
    issue({12'h000, 5'd1, 3'b010, 5'd17, 7'b0000011}, 1'b0, w);
    issue(enc_i(12'd9, 5'd1, 3'd0, 5'd17), 1'b0, w);
    drain();
    chk("illegal_retire", word_t'(retire_count), word_t'(7));
    dbg_chk("dbg_x17", 5'd17, word_t'(0));
    @(negedge clk);

    // ADDI x0,x0,5 retires but x0 stays zero.
    issue(enc_i(12'd5, 5'd0, 3'd0, 5'd0), 1'b0, w);
    drain();
    dbg_chk("x0_zero", 5'd0, word_t'(0));
    chk("x0_retire", word_t'(retire_count), word_t'(8));
    @(negedge clk);

    // instr_valid held high: ready returns exactly every fourth cycle.
    for (int i = 0; i < 8; i++) begin
      issue(rand_instr(), 1'b1, w);
      if (i > 0) chk("burst_ready_gap", word_t'(w), word_t'(3));
    end
    drain();
    dbg_sweep();
    @(negedge clk);

    // Randomized traffic with gaps and junk on the port while busy.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        instr_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      issue(rand_instr(), 1'($urandom_range(0, 1)), w);
    end
    drain();
    dbg_sweep();
    @(negedge clk);

    // Reset during EXECUTE abandons the instruction.
    instr_valid = 1'b1;
    instruction = enc_i(12'd99, 5'd0, 3'd0, 5'd7);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(posedge clk);
    #2 reset_n = 1'b0;
    for (int i = 0; i < 32; i++) mrf[i] = '0;
    mrc = '0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("midrst_ready", word_t'(instr_ready), word_t'(1));
    chk("midrst_retire", word_t'(retire_count), word_t'(0));
    dbg_chk("midrst_x7", 5'd7, word_t'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
